// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the arbiter and uart_tx.
// slave: arbiter side; master: requesters plus uart_tx side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_byte;
  logic                 tx_trigger;
  logic                 tx_ready;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 stall_drop;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_byte, tx_trigger,
    output grant_id, busy, stall_drop
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_byte, tx_trigger,
    input  grant_id, busy, stall_drop
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among NUM_REQ
// byte-stream requesters. Ports: clock, reset (sync, active-high) and
// bus (uart_tx_arbiter_if.slave: req_valid/req_data/req_last/req_ready,
// tx_byte/tx_trigger/tx_ready, grant_id, busy, stall_drop).
// Define UART_ARB_HEADER_EN to prefix each packet with an 8'hA0|id byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int STALL_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CW   = ID_W + 1;
  localparam int SC_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [SC_W-1:0] STALL_LAST =
    SC_W'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);

`ifdef UART_ARB_HEADER_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_FIRE, S_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FIRE, S_WAIT
  } state_t;
`endif

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  pick;
  logic [CW-1:0]    cand;
  logic [7:0]       tx_byte;
  logic             tx_trigger;
  logic             busy;
  logic             stall_drop;
  logic             last_r;
  logic [SC_W-1:0]  stall_cnt;
  logic [NUM_REQ-1:0] ready;
  logic [7:0]       data_arr [NUM_REQ];
  logic [7:0]       g_data;
  logic             g_valid;
  logic             g_last;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = bus.req_data[8*i +: 8];
  end

  assign g_data  = data_arr[grant_id];
  assign g_valid = bus.req_valid[grant_id];
  assign g_last  = bus.req_last[grant_id];

  // Scan downward so the lowest offset from rr_ptr+1 wins last.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ))
        cand = cand - CW'(NUM_REQ);
      if (bus.req_valid[cand[ID_W-1:0]])
        pick = cand[ID_W-1:0];
    end
  end

  always_comb begin
    ready = '0;
    if (state == S_LOAD)
      ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      tx_byte    <= '0;
      tx_trigger <= 1'b0;
      busy       <= 1'b0;
      stall_drop <= 1'b0;
      last_r     <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      tx_trigger <= 1'b0;
      stall_drop <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|bus.req_valid && bus.tx_ready) begin
            grant_id  <= pick;
            stall_cnt <= '0;
            busy      <= 1'b1;
`ifdef UART_ARB_HEADER_EN
            tx_byte    <= 8'hA0 | 8'(pick);
            tx_trigger <= 1'b1;
            state      <= S_HDR;
`else
            state      <= S_LOAD;
`endif
          end
        end
`ifdef UART_ARB_HEADER_EN
        S_HDR: begin
          last_r <= 1'b0;
          state  <= S_WAIT;
        end
`endif
        S_LOAD: begin
          if (g_valid) begin
            tx_byte    <= g_data;
            last_r     <= g_last;
            stall_cnt  <= '0;
            tx_trigger <= 1'b1;
            state      <= S_FIRE;
          end else if (STALL_CYCLES != 0 &&
                       stall_cnt == STALL_LAST) begin
            stall_drop <= 1'b1;
            stall_cnt  <= '0;
            rr_ptr     <= grant_id;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        S_FIRE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // uart_tx drops ready on the edge ending FIRE/HDR.
          if (bus.tx_ready) begin
            if (last_r) begin
              rr_ptr <= grant_id;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.tx_byte    = tx_byte;
  assign bus.tx_trigger = tx_trigger;
  assign bus.grant_id   = grant_id;
  assign bus.busy       = busy;
  assign bus.stall_drop = stall_drop;

endmodule
